// File: rtl/axi_pueo_coeff_loader.sv
// Streams signed 18-bit PUEO coefficients to an AXI-Lite slave as sign-extended 32-bit writes.
// Define COEFF_LOADER_IDENT_CHECK_EN to read and verify the "PUEO" ident word first.
module axi_pueo_coeff_loader #(
    parameter logic [23:0] UPDATE_ADDR = 24'h000700
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic        cmd_update,
    input  logic [17:0] coef_tdata,
    input  logic        coef_tvalid,
    output logic        coef_tready,
    output logic [23:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [23:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [3:0] {
        StIdle, StIdAr, StIdR, StFetch, StWr, StResp, StUpdWr, StUpdResp, StDone
    } state_e;

    localparam logic [31:0] IdentWord = 32'h5055454F;

    state_e      state_q;
    logic [23:0] addr_q, awaddr_q;
    logic [8:0]  cnt_q;
    logic        update_q;
    logic [31:0] wdata_q;
    logic        awvalid_q, wvalid_q, bready_q, coef_tready_q, cmd_ready_q, done_q;
    logic        err_q;
    logic [1:0]  err_code_q;
    logic        arvalid_q, rready_q;
    logic        aw_fin, w_fin, bresp_bad;

    // A channel is finished once its valid has dropped or is being accepted this cycle.
    always_comb begin
        aw_fin    = !awvalid_q || m_axi_awready;
        w_fin     = !wvalid_q || m_axi_wready;
        bresp_bad = (m_axi_bresp != 2'b00) && !err_q;
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            awaddr_q      <= '0;
            cnt_q         <= '0;
            update_q      <= 1'b0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            coef_tready_q <= 1'b0;
            cmd_ready_q   <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= 2'b00;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_ready_q && cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        cnt_q       <= {cmd_len == 8'd0, cmd_len};
                        update_q    <= cmd_update;
                        err_q       <= 1'b0;
                        err_code_q  <= 2'b00;
`ifdef COEFF_LOADER_IDENT_CHECK_EN
                        arvalid_q   <= 1'b1;
                        state_q     <= StIdAr;
`else
                        coef_tready_q <= 1'b1;
                        state_q       <= StFetch;
`endif
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
`ifdef COEFF_LOADER_IDENT_CHECK_EN
                StIdAr: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StIdR;
                    end
                end
                StIdR: begin
                    if (m_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (m_axi_rresp != 2'b00 || m_axi_rdata != IdentWord) begin
                            err_q      <= 1'b1;
                            err_code_q <= (m_axi_rresp != 2'b00) ? 2'b11 : 2'b10;
                            done_q     <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            coef_tready_q <= 1'b1;
                            state_q       <= StFetch;
                        end
                    end
                end
`endif
                StFetch: begin
                    if (coef_tvalid) begin
                        coef_tready_q <= 1'b0;
                        wdata_q       <= {{14{coef_tdata[17]}}, coef_tdata};
                        awaddr_q      <= addr_q;
                        awvalid_q     <= 1'b1;
                        wvalid_q      <= 1'b1;
                        state_q       <= StWr;
                    end
                end
                StWr, StUpdWr: begin
                    if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi_wready) wvalid_q <= 1'b0;
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= (state_q == StWr) ? StResp : StUpdResp;
                    end
                end
                StResp: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (bresp_bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'b01;
                        end
                        addr_q <= addr_q + 24'd4;
                        cnt_q  <= cnt_q - 9'd1;
                        if (cnt_q != 9'd1) begin
                            coef_tready_q <= 1'b1;
                            state_q       <= StFetch;
                        end else if (update_q) begin
                            awaddr_q  <= UPDATE_ADDR;
                            wdata_q   <= '0;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StUpdWr;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StUpdResp: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (bresp_bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'b01;
                        end
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifndef COEFF_LOADER_IDENT_CHECK_EN
    logic unused_ident;
    assign unused_ident = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
                            arvalid_q, rready_q};
    assign m_axi_arvalid = 1'b0;
    assign m_axi_rready  = 1'b0;
`else
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
`endif

    assign m_axi_araddr  = 24'h000000;
    assign cmd_ready     = cmd_ready_q;
    assign coef_tready   = coef_tready_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = err_code_q;

endmodule

// File: tb/tb_axi_pueo_coeff_loader.sv
// Bench for axi_pueo_coeff_loader: table of commands against a reference write-list model,
// randomized AXI slave/stream handshakes, plus stall, reset and ident sequences.
module tb_axi_pueo_coeff_loader;

    localparam logic [23:0] UPD_ADDR = 24'h000700;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_update;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [17:0] coef_tdata;
    logic        coef_tvalid, coef_tready;
    logic [23:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp, err_code;
    logic        busy, done, err;

    axi_pueo_coeff_loader dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_update(cmd_update),
        .coef_tdata(coef_tdata), .coef_tvalid(coef_tvalid), .coef_tready(coef_tready),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready), .m_axi_araddr(araddr), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Slave / source configuration written by the main sequence between commands.
    int          mode = 0;       // 0 always ready, 1 random, 2 awready 3 cycles after W
    int          bad_idx = 999;
    int          b_base = 0, coef_base = 0, n_coefs = 0;
    logic [17:0] coefs[256];
    logic [31:0] ident_word = 32'h5055454F;

    // Monitor state.
    int          cyc = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, coef_idx = 0;
    int          ar_cnt = 0, r_cnt = 0, ar_seen = 0, done_cnt = 0, viol = 0;
    int          w_hs_cyc = 0, r_cyc = 0, done_cyc = 0, aw_wait_cnt = 0;
    logic [23:0] aw_log[$];
    logic [31:0] w_log[$];

    initial begin
        logic        aw_wait, w_wait, lat_pend, done_prev;
        logic [23:0] aw_prev;
        logic [31:0] w_prev;
        aw_wait = 0; w_wait = 0; lat_pend = 0; done_prev = 0;
        aw_prev = '0; w_prev = '0;
        forever begin
            @(posedge clk);
            if (awvalid && aw_cnt > b_cnt) viol++;
            if (wvalid && w_cnt > b_cnt) viol++;
            if (wvalid && wstrb != 4'hF) viol++;
            if (aw_wait && (!awvalid || awaddr != aw_prev)) viol++;
            if (w_wait && (!wvalid || wdata != w_prev)) viol++;
            if (lat_pend && !(awvalid && wvalid)) viol++;
            if (coef_tready && (awvalid || wvalid || bready)) viol++;
            if (done && done_prev) viol++;
            aw_wait = awvalid && !awready;
            w_wait  = wvalid && !wready;
            aw_prev = awaddr;
            w_prev  = wdata;
            lat_pend  = coef_tvalid && coef_tready;
            done_prev = done;
            if (aw_wait) aw_wait_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (arvalid) ar_seen++;
            if (awvalid && awready) begin aw_log.push_back(awaddr); aw_cnt++; end
            if (wvalid && wready) begin w_log.push_back(wdata); w_cnt++; w_hs_cyc = cyc; end
            if (bvalid && bready) b_cnt++;
            if (coef_tvalid && coef_tready) coef_idx++;
            if (arvalid && arready) ar_cnt++;
            if (rvalid && rready) begin r_cnt++; r_cyc = cyc; end
            cyc++;
        end
    end

    // Slave and coefficient source; all DUT inputs except cmd/reset change on the falling edge.
    initial begin
        int b_shown, c_shown, r_shown;
        b_shown = -1; c_shown = -1; r_shown = -1;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rdata = 0; rresp = 0; coef_tvalid = 0; coef_tdata = 0;
        forever begin
            @(negedge clk);
            if (mode == 1) begin
                awready = 1'($urandom_range(0, 1));
                wready  = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                wready  = 1'b1;
                awready = (w_cnt > aw_cnt) && (cyc - w_hs_cyc >= 3);
            end else begin
                awready = 1'b1;
                wready  = 1'b1;
            end
            if (!rst_n) bvalid = 0;
            else if (bvalid && b_cnt == b_shown) bvalid = 1;
            else if (b_cnt < aw_cnt && b_cnt < w_cnt && (mode != 1 || $urandom_range(0, 1) == 1))
            begin
                bvalid  = 1;
                bresp   = (b_cnt - b_base == bad_idx) ? 2'b10 : 2'b00;
                b_shown = b_cnt;
            end else bvalid = 0;
            if (coef_tvalid && coef_idx == c_shown) coef_tvalid = 1;
            else if (coef_idx - coef_base < n_coefs && (mode != 1 || $urandom_range(0, 1) == 1))
            begin
                coef_tvalid = 1;
                coef_tdata  = coefs[coef_idx - coef_base];
                c_shown     = coef_idx;
            end else coef_tvalid = 0;
            arready = (mode != 1) || ($urandom_range(0, 1) == 1);
            if (rvalid && r_cnt == r_shown) rvalid = 1;
            else if (r_cnt < ar_cnt) begin
                rvalid = 1; rdata = ident_word; rresp = 2'b00; r_shown = r_cnt;
            end else rvalid = 0;
        end
    end

    // Reference model: word k of a command is written to base+4k (24-bit wrap) carrying the
    // sign-extended coefficient; an optional final write carries 0 to the commit address.
    function automatic logic [23:0] model_addr(input logic [23:0] base, input int k, input int nd);
        if (k >= nd) return UPD_ADDR;
        return base + 24'(4 * k);
    endfunction

    function automatic logic [31:0] model_data(input logic [17:0] c, input int k, input int nd);
        int v;
        if (k >= nd) return 32'h0;
        v = $signed(c);
        return v;
    endfunction

    task automatic send_cmd(input logic [23:0] a, input logic [7:0] l, input logic u);
        @(posedge clk); #1;
        cmd_valid = 1; cmd_addr = a; cmd_len = l; cmd_update = u;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_done(output logic seen);
        seen = 0;
        for (int t = 0; t < 20000; t++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1; break; end
        end
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  len;
        logic        upd;
        int          mode;
        int          bad;
        int          exp_nw;
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic seen;
        int   ab, wb, db, awb, nd, mism;
        rst_n = 0; cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_update = 0;
        vecs[0] = '{24'h000400, 8'd3, 1'b0, 0, 999, 3,   1'b0, 2'b00};
        vecs[1] = '{24'h000100, 8'd1, 1'b1, 2, 999, 2,   1'b0, 2'b00};
        vecs[2] = '{24'h000200, 8'd4, 1'b0, 0, 1,   4,   1'b1, 2'b01};
        vecs[3] = '{24'h123454, 8'd5, 1'b1, 1, 999, 6,   1'b0, 2'b00};
        vecs[4] = '{24'hFFFFF0, 8'd6, 1'b0, 1, 0,   6,   1'b1, 2'b01};
        vecs[5] = '{24'h000000, 8'd2, 1'b1, 1, 2,   3,   1'b1, 2'b01};
        vecs[6] = '{24'hFFFFF8, 8'd0, 1'b0, 0, 999, 256, 1'b0, 2'b00};

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {cmd_ready, coef_tready, awvalid, wvalid, bready, arvalid,
                                rready, busy, done, err, err_code}, 12'h000);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        check("cmd_ready_after_reset", cmd_ready, 1);

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            nd = (vecs[i].len == 0) ? 256 : int'(vecs[i].len);
            coef_base = coef_idx;
            for (int k = 0; k < nd; k++) coefs[k] = 18'($urandom_range(0, 32'h3FFFF));
            if (i == 0) begin
                coefs[0] = 18'h00001; coefs[1] = 18'h3FFFE; coefs[2] = 18'h1FFFF;
            end
            n_coefs = nd; mode = vecs[i].mode; bad_idx = vecs[i].bad;
            b_base = b_cnt; ab = aw_cnt; wb = w_cnt; db = done_cnt; awb = aw_wait_cnt;
            send_cmd(vecs[i].addr, vecs[i].len, vecs[i].upd);
            wait_done(seen);
            check($sformatf("v%0d_done_seen", i), seen, 1);
            @(posedge clk); #1;
            check($sformatf("v%0d_aw_count", i), aw_cnt - ab, vecs[i].exp_nw);
            check($sformatf("v%0d_w_count", i), w_cnt - wb, vecs[i].exp_nw);
            mism = 0;
            for (int k = 0; k < vecs[i].exp_nw && k < aw_cnt - ab && k < w_cnt - wb; k++) begin
                if (aw_log[ab + k] !== model_addr(vecs[i].addr, k, nd)) mism++;
                if (w_log[wb + k] !== model_data(coefs[k], k, nd)) mism++;
            end
            check($sformatf("v%0d_write_content", i), mism, 0);
            check($sformatf("v%0d_err", i), {err, err_code}, {vecs[i].exp_err, vecs[i].exp_code});
            check($sformatf("v%0d_done_pulses", i), done_cnt - db, 1);
            if (i == 0 && w_cnt - wb >= 3) begin
                check("v0_word1", w_log[wb + 1], 32'hFFFFFFFE);
                check("v0_word2", w_log[wb + 2], 32'h0001FFFF);
                check("v0_addr1", aw_log[ab + 1], 24'h000404);
            end
            if (i == 1) check("v1_aw_waited", (aw_wait_cnt - awb) >= 3, 1);
            if (i == 6 && aw_cnt - ab >= 3) check("v6_wrap_addr3", aw_log[ab + 2], 24'h000000);
        end

        // Coefficient stream held off: loader must sit in FETCH with nothing on the bus.
        @(posedge clk); #1;
        coef_base = coef_idx; n_coefs = 0; mode = 0; bad_idx = 999;
        coefs[0] = 18'h2ABCD; b_base = b_cnt; ab = aw_cnt; wb = w_cnt; db = done_cnt;
        send_cmd(24'h000040, 8'd1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("stall_outputs", {coef_tready, awvalid, wvalid, bready, busy}, 5'b10001);
        n_coefs = 1;
        wait_done(seen);
        check("stall_done_seen", seen, 1);
        check("stall_write", {aw_cnt - ab == 1, w_log[wb]}, {1'b1, 32'hFFFEABCD});

`ifdef COEFF_LOADER_IDENT_CHECK_EN
        @(posedge clk); #1;
        ident_word = 32'hDEADBEEF; coef_base = coef_idx; n_coefs = 0;
        ab = aw_cnt; db = done_cnt;
        send_cmd(24'h000080, 8'd2, 1'b1);
        wait_done(seen);
        check("ident_done_seen", seen, 1);
        @(posedge clk); #1;
        check("ident_no_writes", aw_cnt - ab, 0);
        check("ident_err", {err, err_code}, 3'b110);
        check("ident_done_latency", done_cyc - r_cyc, 1);
        ident_word = 32'h5055454F;
`else
        check("no_ar_activity", ar_seen, 0);
`endif
        check("protocol_violations", viol, 0);

        // Reset in the middle of a 256-word load.
        @(posedge clk); #1;
        nd = 256; coef_base = coef_idx;
        for (int k = 0; k < nd; k++) coefs[k] = 18'($urandom_range(0, 32'h3FFFF));
        n_coefs = nd; mode = 0; bad_idx = 999; b_base = b_cnt; ab = aw_cnt;
        send_cmd(24'hFFFFF8, 8'd0, 1'b0);
        seen = 0;
        for (int t = 0; t < 2000; t++) begin
            @(posedge clk); #1;
            if (aw_cnt - ab >= 5) begin seen = 1; break; end
        end
        check("rst_stream_progress", seen, 1);
        if (seen) check("rst_wrap_addr3", aw_log[ab + 2], 24'h000000);
        db = done_cnt;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("rst_mid_outputs", {awvalid, wvalid, bready, coef_tready, cmd_ready, done,
                                  busy, err, arvalid, rready}, 10'h000);
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        check("rst_cmd_ready", cmd_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_done", {done_cnt - db, busy, awvalid, wvalid}, {32'd0, 3'b000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_pueo_coeff_loader.md
AXI_PUEO_COEFF_LOADER -- requirements
Module: axi_pueo_coeff_loader

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: m_axi_aclk in 1 (all logic rising-edge), m_axi_aresetn in 1 (async assert, active low).
REQ-002 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_addr in 24 (first word byte address), cmd_len in 8 (word count, 0 = 256), cmd_update in 1 (append commit write).
REQ-003 SHALL have coef_tdata in 18 (signed coefficient), coef_tvalid in 1, coef_tready out 1.
REQ-004 SHALL have m_axi_awaddr out 24, m_axi_awvalid out 1, m_axi_awready in 1, m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wvalid out 1, m_axi_wready in 1.
REQ-005 SHALL have m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1, m_axi_araddr out 24, m_axi_arvalid out 1, m_axi_arready in 1, m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1.
REQ-006 SHALL have busy out 1 (state != IDLE), done out 1 (one-cycle pulse), err out 1 (sticky), err_code out 2 (01 bad BRESP, 10 ident mismatch, 11 bad RRESP).
REQ-007 SHALL have parameter UPDATE_ADDR, default 24'h000700, meaning commit-write byte address.

Function
REQ-008 SHALL implement states IDLE, ID_AR, ID_R, FETCH, WR, RESP, UPD_WR, UPD_RESP, DONE.
REQ-009 IDLE: cmd_ready=1; on cmd_valid latch addr/len/update, clear err/err_code, go to ID_AR (macro on) or FETCH (macro off).
REQ-010 FETCH: coef_tready=1; on coef_tvalid latch sign-extended coef_tdata into wdata[31:0], go to WR.
REQ-011 WR: assert awvalid and wvalid in the same cycle; each held, with stable payload, until its own ready seen; channels complete independently, in either order or together; go to RESP when both done.
REQ-012 RESP: bready=1; on bvalid decrement remaining count, add 4 to address modulo 2^24; go to FETCH if words remain, else UPD_WR if update latched, else DONE.
REQ-013 A nonzero bresp SHALL set err, err_code=01 (first error only retained), and the sequence SHALL continue.
REQ-014 UPD_WR/UPD_RESP: same handshake as WR/RESP with awaddr=UPDATE_ADDR, wdata=0; then DONE.
REQ-015 DONE: pulse done for exactly one cycle, return to IDLE.
REQ-016 wstrb SHALL be 4'hF on every write; at most one write outstanding; awvalid/wvalid never asserted before the previous bvalid is accepted.
REQ-017 cmd_len=0 SHALL issue 256 data writes; address wrap from 24'hFFFFFC continues at 24'h000000.
REQ-018 coef_tready SHALL be 0 outside FETCH; coef_tvalid held low SHALL stall in FETCH indefinitely with all AXI valids low.
REQ-019 Latency: coefficient accepted in FETCH at cycle N -> awvalid/wvalid high at N+1.

Reset
REQ-020 While m_axi_aresetn=0: state IDLE, all valids/readies and done/err/busy low, err_code 0, cmd_ready low; cmd_ready goes high the first cycle after deassertion.
REQ-021 Reset mid-transaction SHALL abandon the transaction with no further handshakes and no done pulse.

Configuration
REQ-022 Macro COEFF_LOADER_IDENT_CHECK_EN SHALL compile in the ident check; when absent, ID_AR/ID_R and all AR/R logic are removed, arvalid and rready tie to 0.
REQ-023 With the macro: ID_AR asserts arvalid, araddr=24'h000000 until arready; ID_R asserts rready until rvalid; rdata=="PUEO" (32'h5055454F) and rresp==0 -> FETCH.
REQ-024 With the macro, on ident mismatch set err_code=10 (rresp nonzero: 11), set err, write nothing, go to DONE.

Verification
REQ-025 cmd addr=0x400 len=3 update=0, coefs 1,-2,0x1FFFF with ready always high -> writes 0x400=0x00000001, 0x404=0xFFFFFFFE, 0x408=0x0001FFFF, one done pulse, err=0.
REQ-026 len=1 update=1, awready delayed 3 cycles after wready -> awaddr/wdata stable while waiting, then write to 0x700 data 0, done.
REQ-027 bresp=2'b10 on the 2nd of 4 writes -> err=1, err_code=01, all 4 writes still issued, done pulses.
REQ-028 Macro on, rdata=0xDEADBEEF -> no AW/W activity, err_code=10, done one cycle after rvalid accepted.
REQ-029 len=0 from addr=0xFFFFF8 -> 256 writes, 3rd awaddr=0x000000; m_axi_aresetn pulsed low mid-stream -> all valids drop immediately, no done pulse, cmd_ready high after release.
